// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake and operand/result bus of the sequential restoring divider.
interface seq_restoring_divider_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Requester side: issues operands, observes results
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, using
// A + ~M + 1 with carry-out as the "no borrow" decision.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int unsigned AW = WIDTH + 1;   // partial remainder width
  localparam int unsigned TW = AW + 1;      // trial sum width incl. carry-out
  localparam int unsigned SW = AW + WIDTH;  // combined {A,Q} shift width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    a_q, a_d;
  logic [AW-1:0]    m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [SW-1:0]    aq_sh;
  logic [AW-1:0]    a_sh;
  logic [WIDTH-1:0] q_sh;
  logic [TW-1:0]    trial;
  logic             no_borrow;

  // One iteration: shift {A,Q} left, then trial-subtract M by two's complement
  always_comb begin
    aq_sh     = {a_q, q_q} << 1;
    a_sh      = aq_sh[SW-1:WIDTH];
    q_sh      = aq_sh[WIDTH-1:0];
    trial     = {1'b0, a_sh} + {1'b0, ~m_q} + TW'(1);
    no_borrow = trial[TW-1];
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d   = '0;
          q_d   = bus.dividend;
          m_d   = {1'b0, bus.divisor};
          cnt_d = CNT_W'(WIDTH);
          dbz_d = 1'b0;
          if (bus.divisor == '0) begin
            // Divide-by-zero finishes immediately with fixed results
            state_d = DONE;
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        a_d   = no_borrow ? trial[AW-1:0] : a_sh;
        q_d   = q_sh | WIDTH'(no_borrow);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          quot_d  = q_d;
          rem_d   = a_d[WIDTH-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases, an exhaustive
// 4-bit sweep and random pairs checked against integer division.
module tb_seq_restoring_divider;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 3;
  localparam int          MAXV  = (1 << WIDTH) - 1;

  logic clk = 1'b0;
  logic rst_n;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_restoring_divider #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division with the divide-by-zero convention
  function automatic void ref_div(input int dd, input int dv, output int q, output int r, output int z);
    if (dv == 0) begin
      q = MAXV;
      r = dd;
      z = 1;
    end else begin
      q = dd / dv;
      r = dd % dv;
      z = 0;
    end
  endfunction

  // Issue one division from IDLE, wait for done, check results and timing
  task automatic run_div(input int dd, input int dv, input string tag);
    int eq, er, ez;
    int edges, busy_cnt;
    ref_div(dd, dv, eq, er, ez);
    bus.start    = 1'b1;
    bus.dividend = WIDTH'(dd);
    bus.divisor  = WIDTH'(dv);
    tick();
    bus.start    = 1'b0;
    bus.dividend = WIDTH'($urandom);
    bus.divisor  = WIDTH'($urandom);
    if (dv != 0) check({tag, " dbz_clear"}, 32'(bus.div_by_zero), 32'd0);
    edges    = 0;
    busy_cnt = 0;
    while (!bus.done && edges < 4 * WIDTH) begin
      if (bus.busy) busy_cnt++;
      tick();
      edges++;
    end
    check({tag, " latency"}, 32'(edges), (dv == 0) ? 32'd0 : 32'(WIDTH));
    check({tag, " busy_cycles"}, 32'(busy_cnt), (dv == 0) ? 32'd0 : 32'(WIDTH));
    check({tag, " quotient"}, 32'(bus.quotient), 32'(eq));
    check({tag, " remainder"}, 32'(bus.remainder), 32'(er));
    check({tag, " div_by_zero"}, 32'(bus.div_by_zero), 32'(ez));
    if (dv != 0) begin
      check({tag, " invariant"}, 32'(int'(bus.quotient) * dv + int'(bus.remainder)), 32'(dd));
      check({tag, " rem_lt_div"}, 32'(int'(bus.remainder) < dv), 32'd1);
    end
    tick();
    check({tag, " done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  // Global time limit so the run always ends
  initial begin
    #2ms;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dcnt, edges;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    tick();
    tick();
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst quotient", 32'(bus.quotient), 32'd0);
    check("rst remainder", 32'(bus.remainder), 32'd0);
    check("rst dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    tick();

    run_div(13, 3, "t1_13_3");

    run_div(15, 1, "t2_15_1");
    run_div(3, 9, "t2_3_9");
    run_div(0, 5, "t2_0_5");
    run_div(15, 15, "t2_15_15");

    run_div(7, 0, "t3_7_0");
    run_div(9, 2, "t3_9_2");

    // Starts during RUN and DONE must be ignored
    bus.start    = 1'b1;
    bus.dividend = WIDTH'(14);
    bus.divisor  = WIDTH'(4);
    tick();
    bus.start = 1'b0;
    tick();
    bus.start    = 1'b1;
    bus.dividend = WIDTH'(1);
    bus.divisor  = WIDTH'(1);
    tick();
    bus.start = 1'b0;
    check("t4 held_quotient", 32'(bus.quotient), 32'd4);
    check("t4 held_remainder", 32'(bus.remainder), 32'd1);
    edges = 2;
    dcnt  = 0;
    while (!bus.done && edges < 4 * WIDTH) begin
      tick();
      edges++;
    end
    check("t4 latency", 32'(edges), 32'(WIDTH));
    check("t4 quotient", 32'(bus.quotient), 32'd3);
    check("t4 remainder", 32'(bus.remainder), 32'd2);
    if (bus.done) dcnt++;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    if (bus.done) dcnt++;
    check("t4 busy_after_done_start", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done) dcnt++;
    end
    check("t4 done_count", 32'(dcnt), 32'd1);
    check("t4 still_idle", 32'(bus.busy), 32'd0);
    run_div(1, 1, "t4_next");

    // Reset in the middle of a division
    bus.start    = 1'b1;
    bus.dividend = WIDTH'(11);
    bus.divisor  = WIDTH'(2);
    tick();
    bus.start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5 busy", 32'(bus.busy), 32'd0);
    check("t5 done", 32'(bus.done), 32'd0);
    check("t5 quotient", 32'(bus.quotient), 32'd0);
    check("t5 remainder", 32'(bus.remainder), 32'd0);
    check("t5 dbz", 32'(bus.div_by_zero), 32'd0);
    dcnt = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      tick();
      if (bus.done || bus.busy) dcnt++;
    end
    check("t5 no_activity", 32'(dcnt), 32'd0);
    run_div(11, 2, "t5_11_2");

    // Exhaustive back-to-back sweep
    for (int dd = 0; dd <= MAXV; dd++) begin
      for (int dv = 0; dv <= MAXV; dv++) begin
        run_div(dd, dv, $sformatf("sweep_%0d_%0d", dd, dv));
      end
    end

    // Random pairs
    for (int i = 0; i < 40; i++) begin
      int dd, dv;
      dd = int'($urandom_range(MAXV, 0));
      dv = int'($urandom_range(MAXV, 0));
      run_div(dd, dv, $sformatf("rand_%0d_%0d", dd, dv));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
